dec_comm_nch_batch: RTL

Next-generation UDP packetizer for acquisition data. It reads N_CH parallel show-ahead sample FIFOs that are popped together, and batches a runtime-selectable number of samples into one UDP payload. Each payload carries a mode byte and a sequence byte. The block honours tx FIFO backpressure and flushes short packets on a timeout. It sits between the acquisition FIFOs and the 1 GbE tx data/status FIFOs, in place of the fixed 4-channel, single-sample decoder.

---
 rtl/dec_comm_pkg.sv | 35 +++
 rtl/dec_comm_byte_sel.sv | 28 ++
 rtl/dec_comm_nch_batch.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/dec_comm_pkg.sv
// Shared definitions for the N-channel batching UDP packetizer:
// state encoding, header size and small helper functions.
package dec_comm_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_HDR_MODE,
      ST_HDR_SEQ,
      ST_DATA,
      ST_POP,
      ST_POP_WAIT,
      ST_WAIT_SAMPLE,
      ST_STATUS,
      ST_DONE
   } state_t;

   localparam int HEADER_BYTES = 2;

   function automatic int bytes_per_sample(input int n_ch, input int fifo_length,
                                           input int byte_size);
      return n_ch * fifo_length / byte_size;
   endfunction

   function automatic logic [7:0] mode_byte(input logic circle, input logic position);
      return {{4{circle}}, {4{position}}};
   endfunction

   // Requested batch size forced into 1..max_samples; zero means a single sample.
   function automatic logic [7:0] clamp_samples(input logic [7:0] req, input int max_samples);
      if (req == 8'd0) return 8'd1;
      if (int'(req) > max_samples) return 8'(max_samples);
      return req;
   endfunction

endpackage

// File: rtl/dec_comm_byte_sel.sv
// Combinational byte picker: selects byte byte_idx (0 = MSB) of channel ch_idx
// from the concatenated show-ahead channel FIFO outputs.
module dec_comm_byte_sel #(
   parameter int N_CH        = 4,
   parameter int FIFO_LENGTH = 64,
   parameter int BYTE_SIZE   = 8,
   parameter int CH_W        = 2,
   parameter int BI_W        = 3
) (
   input  logic [N_CH*FIFO_LENGTH-1:0] rddata_fifos,
   input  logic [CH_W-1:0]             ch_idx,
   input  logic [BI_W-1:0]             byte_idx,
   output logic [BYTE_SIZE-1:0]        o_byte
);

   localparam int BPC = FIFO_LENGTH / BYTE_SIZE;

   always_comb begin
      o_byte = '0;
      for (int k = 0; k < N_CH; k++) begin
         for (int b = 0; b < BPC; b++) begin
            if (ch_idx == CH_W'(k) && byte_idx == BI_W'(b))
               o_byte = rddata_fifos[(k+1)*FIFO_LENGTH-1-b*BYTE_SIZE -: BYTE_SIZE];
         end
      end
   end

endmodule

// File: rtl/dec_comm_nch_batch.sv
// UDP packetizer: batches samples from N_CH jointly-popped channel FIFOs into one
// payload with mode and sequence header bytes, honouring backpressure and flushing on timeout.
module dec_comm_nch_batch
   import dec_comm_pkg::*;
#(
   parameter int AVL_SIZE      = 8,
   parameter int BYTE_SIZE     = 8,
   parameter int IP_SIZE       = 32,
   parameter int MAC_SIZE      = 48,
   parameter int FIFO_LENGTH   = 64,
   parameter int N_CH          = 4,
   parameter int MAX_SAMPLES   = 16,
   parameter int FLUSH_TIMEOUT = 1024
) (
   input  logic                                   clk,
   input  logic                                   reset,
   output logic [AVL_SIZE-1:0]                    tx_fifo_data,
   output logic [2*BYTE_SIZE+IP_SIZE+MAC_SIZE-1:0] tx_fifo_status,
   output logic                                   tx_fifo_data_write,
   output logic                                   tx_fifo_status_write,
   input  logic                                   tx_fifo_data_full,
   input  logic                                   tx_fifo_status_full,
   input  logic [MAC_SIZE-1:0]                    destination_mac,
   input  logic [IP_SIZE-1:0]                     destination_ip,
   input  logic                                   atommode_circle_nlegacy,
   input  logic                                   atommode_position_nerror,
   input  logic [7:0]                             samples_per_packet,
   output logic                                   rdreq_fifos,
   input  logic [N_CH*FIFO_LENGTH-1:0]            rddata_fifos,
   input  logic [N_CH-1:0]                        rdempty_fifos,
   output logic                                   busy
);

   localparam int BPC   = FIFO_LENGTH / BYTE_SIZE;
   localparam int BPS   = bytes_per_sample(N_CH, FIFO_LENGTH, BYTE_SIZE);
   localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int BI_W  = (BPC > 1) ? $clog2(BPC) : 1;
   localparam int TO_W  = $clog2(FLUSH_TIMEOUT + 1);
   localparam int LEN_W = 2 * BYTE_SIZE;

   localparam logic [CH_W-1:0] LAST_CH   = CH_W'(N_CH - 1);
   localparam logic [BI_W-1:0] LAST_BYTE = BI_W'(BPC - 1);
   localparam logic [TO_W-1:0] LAST_TICK = TO_W'(FLUSH_TIMEOUT - 1);

   state_t                                r_state;
   logic [7:0]                            r_mode;
   logic [7:0]                            r_seq;
   logic [7:0]                            r_n_target;
   logic [7:0]                            r_samples_sent;
   logic [CH_W-1:0]                       r_ch_idx;
   logic [BI_W-1:0]                       r_byte_idx;
   logic [TO_W-1:0]                       r_timeout;
   logic [AVL_SIZE-1:0]                   r_data;
   logic                                  r_data_write;
   logic [2*BYTE_SIZE+IP_SIZE+MAC_SIZE-1:0] r_status;
   logic                                  r_status_write;
   logic                                  r_rdreq;

   logic [BYTE_SIZE-1:0]                  w_byte;
   logic [LEN_W-1:0]                      w_length;
   logic                                  w_unused_empty;

   // Only channel 0's empty flag steers the FSM; the others pop in lockstep.
   assign w_unused_empty = &{1'b0, rdempty_fifos};

   assign w_length = LEN_W'(HEADER_BYTES) + LEN_W'(r_samples_sent) * LEN_W'(BPS);

   dec_comm_byte_sel #(
      .N_CH       (N_CH),
      .FIFO_LENGTH(FIFO_LENGTH),
      .BYTE_SIZE  (BYTE_SIZE),
      .CH_W       (CH_W),
      .BI_W       (BI_W)
   ) u_byte_sel (
      .rddata_fifos(rddata_fifos),
      .ch_idx      (r_ch_idx),
      .byte_idx    (r_byte_idx),
      .o_byte      (w_byte)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state        <= ST_IDLE;
         r_mode         <= '0;
         r_seq          <= '0;
         r_n_target     <= '0;
         r_samples_sent <= '0;
         r_ch_idx       <= '0;
         r_byte_idx     <= '0;
         r_timeout      <= '0;
         r_data         <= '0;
         r_data_write   <= 1'b0;
         r_status       <= '0;
         r_status_write <= 1'b0;
         r_rdreq        <= 1'b0;
      end else begin
         // NOTE: strobes default low every cycle, so any state that asserts one yields a one-cycle pulse.
         r_data_write   <= 1'b0;
         r_status_write <= 1'b0;
         r_rdreq        <= 1'b0;
         unique case (r_state)
            ST_IDLE: begin
               if (!rdempty_fifos[0] && !tx_fifo_status_full) begin
                  r_mode         <= mode_byte(atommode_circle_nlegacy, atommode_position_nerror);
                  r_n_target     <= clamp_samples(samples_per_packet, MAX_SAMPLES);
                  r_samples_sent <= '0;
                  r_ch_idx       <= '0;
                  r_byte_idx     <= '0;
                  r_timeout      <= '0;
                  r_state        <= ST_HDR_MODE;
               end
            end
            ST_HDR_MODE: begin
               if (!tx_fifo_data_full) begin
                  r_data       <= AVL_SIZE'(r_mode);
                  r_data_write <= 1'b1;
                  r_state      <= ST_HDR_SEQ;
               end
            end
            ST_HDR_SEQ: begin
               if (!tx_fifo_data_full) begin
                  r_data       <= AVL_SIZE'(r_seq);
                  r_data_write <= 1'b1;
                  r_state      <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (!tx_fifo_data_full) begin
                  r_data       <= AVL_SIZE'(w_byte);
                  r_data_write <= 1'b1;
                  if (r_byte_idx == LAST_BYTE) begin
                     r_byte_idx <= '0;
                     if (r_ch_idx == LAST_CH) begin
                        r_ch_idx <= '0;
                        r_rdreq  <= 1'b1;
                        r_state  <= ST_POP;
                     end else begin
                        r_ch_idx <= r_ch_idx + CH_W'(1);
                     end
                  end else begin
                     r_byte_idx <= r_byte_idx + BI_W'(1);
                  end
               end
            end
            ST_POP: begin
               r_samples_sent <= r_samples_sent + 8'd1;
               r_state        <= ST_POP_WAIT;
            end
            ST_POP_WAIT: begin
               r_state <= (r_samples_sent == r_n_target) ? ST_STATUS : ST_WAIT_SAMPLE;
            end
            ST_WAIT_SAMPLE: begin
               if (!rdempty_fifos[0]) begin
                  r_timeout <= '0;
                  r_state   <= ST_DATA;
               end else if (r_timeout == LAST_TICK) begin
                  r_timeout <= '0;
                  r_state   <= ST_STATUS;
               end else begin
                  r_timeout <= r_timeout + TO_W'(1);
               end
            end
            ST_STATUS: begin
               if (!tx_fifo_status_full) begin
                  r_status       <= {w_length, destination_ip, destination_mac};
                  r_status_write <= 1'b1;
                  r_seq          <= r_seq + 8'd1;
                  r_state        <= ST_DONE;
               end
            end
            ST_DONE: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign tx_fifo_data         = r_data;
   assign tx_fifo_data_write   = r_data_write;
   assign tx_fifo_status       = r_status;
   assign tx_fifo_status_write = r_status_write;
   assign rdreq_fifos          = r_rdreq;
   assign busy                 = (r_state != ST_IDLE);

endmodule
